// File: rtl/apu_ipc_mailbox.sv
// Host<->APU message mailbox: two independent FIFOs (H2A, A2H) with
// registered level interrupts and sticky overflow flags.
module apu_ipc_mailbox #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  host_wdata,
  input  logic          host_wen,
  input  logic          host_ren,
  output logic [W-1:0]  host_rdata,
  output logic [CW-1:0] host_rx_level,
  output logic [CW-1:0] host_tx_level,
  input  logic          host_irq_en,
  output logic          host_irq,
  output logic          host_ovf,
  input  logic          host_ovf_clr,
  input  logic          host_flush,
  input  logic [W-1:0]  apu_wdata,
  input  logic          apu_wen,
  input  logic          apu_ren,
  output logic [W-1:0]  apu_rdata,
  output logic [CW-1:0] apu_rx_level,
  input  logic          apu_irq_en,
  output logic          apu_irq,
  output logic          apu_ovf,
  input  logic          apu_ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Index 0 is H2A (host writes, APU reads); index 1 is A2H (APU writes, host reads).
  logic [W-1:0]  mem_q [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [PW-1:0] level_q [2];
  logic [PW-1:0] level_d [2];
  logic [W-1:0]  wdata [2];
  logic [W-1:0]  rdata [2];
  logic [1:0]    wen, ren, full, empty, push, pop;
  logic [1:0]    ovf_q, ovf_d, ovf_clr, irq_en, irq_q, irq_d;

  assign wdata[0] = host_wdata;
  assign wdata[1] = apu_wdata;
  assign wen      = {apu_wen, host_wen};
  assign ren      = {host_ren, apu_ren};
  assign ovf_clr  = {apu_ovf_clr, host_ovf_clr};
  assign irq_en   = {host_irq_en, apu_irq_en};

  always_comb begin
    push = '0;
    pop  = '0;
    full = '0;
    empty = '0;
    ovf_d = '0;
    irq_d = '0;
    for (int i = 0; i < 2; i++) begin
      level_q[i] = wptr_q[i] - rptr_q[i];
      // Full when the pointers differ only in the wrap bit.
      full[i]    = (wptr_q[i] == {~rptr_q[i][PW-1], rptr_q[i][AW-1:0]});
      empty[i]   = (wptr_q[i] == rptr_q[i]);
      push[i]    = wen[i] & ~full[i];
      pop[i]     = ren[i] & ~empty[i];
      wptr_d[i]  = host_flush ? '0 : wptr_q[i] + PW'(push[i]);
      rptr_d[i]  = host_flush ? '0 : rptr_q[i] + PW'(pop[i]);
      level_d[i] = wptr_d[i] - rptr_d[i];
      ovf_d[i]   = (wen[i] & full[i]) | (ovf_q[i] & ~ovf_clr[i]);
      irq_d[i]   = irq_en[i] & (level_d[i] != '0);
      rdata[i]   = empty[i] ? '0 : mem_q[i][rptr_q[i][AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      ovf_q <= '0;
      irq_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  // Storage needs no reset: reads of an empty FIFO are forced to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= wdata[i];
    end
  end

  assign apu_rdata     = rdata[0];
  assign host_rdata    = rdata[1];
  assign apu_rx_level  = CW'(level_q[0]);
  assign host_tx_level = CW'(level_q[0]);
  assign host_rx_level = CW'(level_q[1]);
  assign host_ovf      = ovf_q[0];
  assign apu_ovf       = ovf_q[1];
  assign apu_irq       = irq_q[0];
  assign host_irq      = irq_q[1];

endmodule
